mult_pair_monitor: RTL
======================

Name: mult_pair_monitor

Overview:
Downstream checker for a pair of sequential shift-add multiplier instances that share one `start`. It times each instance's `productDone` relative to the shared `start` and captures both products. It then reports per-operation latencies, a timing-leak flag for any cycle where the two done states diverge, and a product-mismatch flag. This is the consumer stage that turns raw multiplier outputs into the `timingLeak`, `timingLeakDone` and commutativity results used by the multiplier tester.

Parameters:
- WIDTH, 1024, operand width of monitored multipliers; products are 2*WIDTH bits.
- CNT_W, 16, latency counter width; must satisfy 2^CNT_W > TIMEOUT.
- TIMEOUT, 4200, max cycles to wait for both done signals before aborting.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  same start pulse driven to both multipliers.
- productA  input  2*WIDTH  product of instance A.
- productDoneA  input  1  done level/pulse of instance A.
- productB  input  2*WIDTH  product of instance B.
- productDoneB  input  1  done level/pulse of instance B.
- busy  output  1  high in RUN.
- timingLeak  output  1  sticky; done states of A and B differed in some RUN cycle.
- timingLeakDone  output  1  result of the last check is valid (level).
- productMismatch  output  1  captured productA != captured productB (valid when timingLeakDone).
- timeout  output  1  last check aborted by TIMEOUT.
- checkDone  output  1  one-cycle pulse when a check completes.
- latencyA  output  CNT_W  cycles from start to first productDoneA.
- latencyB  output  CNT_W  cycles from start to first productDoneB.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE. All outputs 0, counter 0, captured products 0, seenA/seenB 0. Reset mid-RUN aborts immediately with no checkDone pulse.
- FSM states: IDLE, RUN, REPORT.
- IDLE:
  - start=1 sampled at edge E0 -> RUN.
  - Same edge: cnt<=0; seenA,seenB,timingLeak,timingLeakDone,productMismatch,timeout<=0; latencyA,latencyB<=0.
- RUN (each edge):
  - cnt<=cnt+1; cnt saturates at TIMEOUT.
  - If productDoneA && !seenA: seenA<=1, latencyA<=cnt+1, capA<=productA. Same for B.
  - Done state per side: dA=seenA|productDoneA, dB=seenB|productDoneB. If dA!=dB: timingLeak<=1 (sticky).
  - Done high after its first capture is ignored.
  - If both sides' done states are set this cycle (including via same-cycle captures) -> REPORT.
  - Else if cnt+1==TIMEOUT -> REPORT with timeout<=1; latency of an uncaptured side stays 0.
  - start during RUN is ignored.
- Latency definition: productDone high in the first RUN cycle (edge E1) gives latency 1.
- REPORT (exactly one cycle):
  - checkDone=1.
  - productMismatch<=(capA!=capB) when !timeout. On timeout, productMismatch<=0.
  - timingLeakDone<=1.
  - Next state IDLE; start in REPORT is ignored.
- Result hold: timingLeak, timingLeakDone, productMismatch, timeout and latencies hold until the next accepted start or reset.
- Simultaneous done: A and B first high in the same cycle do not set timingLeak.
- Comparison: full 2*WIDTH equality, unsigned.
- Area: cnt and latencies are CNT_W bits; the capture registers are 2*WIDTH each.

Test Plan:
- WIDTH=8. start at E0; both done first high at E9; productA=productB=0x0C35 -> latencyA=latencyB=9, timingLeak=0, productMismatch=0, checkDone pulse at E10, timingLeakDone=1 thereafter.
- A done at E9, B done at E12; equal products -> latencyA=9, latencyB=12, timingLeak=1 from E9, productMismatch=0, checkDone at E13.
- Both done at E5; productA=0x0064, productB=0x0065 -> productMismatch=1, timingLeak=0.
- TIMEOUT=20; A done at E4, B never done -> timeout=1, latencyA=4, latencyB=0, timingLeak=1, productMismatch=0, checkDone exactly once.
- rst at E6 mid-RUN -> next cycle all outputs 0, busy=0, no checkDone. A new start then runs a clean check with latencies measured from the new start.
- Extra start pulses at E3 (RUN) and at the REPORT cycle -> ignored; busy falls after REPORT. Latencies are unchanged; the following start in IDLE clears the results.

Source files
------------

// File: rtl/mult_pair_monitor.sv
// Monitors two multiplier instances that share one start pulse. It times each productDone
// against that start, captures both products, and reports latencies, divergence and mismatch.
module mult_pair_monitor #(
  parameter int WIDTH   = 1024,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   productA,
  input  logic                 productDoneA,
  input  logic [2*WIDTH-1:0]   productB,
  input  logic                 productDoneB,
  output logic                 busy,
  output logic                 timingLeak,
  output logic                 timingLeakDone,
  output logic                 productMismatch,
  output logic                 timeout,
  output logic                 checkDone,
  output logic [CNT_W-1:0]     latencyA,
  output logic [CNT_W-1:0]     latencyB
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // state is the observable FSM register; state_next is its combinational successor.
  state_t               state;
  state_t               state_next;

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 seen_a;
  logic                 seen_b;
  logic                 done_a;
  logic                 done_b;
  logic                 both_done;
  logic                 hit_timeout;
  logic                 cap_a_en;
  logic                 cap_b_en;
  logic [2*WIDTH-1:0]   cap_a;
  logic [2*WIDTH-1:0]   cap_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A side counts as done from the cycle its first done is seen onwards, so a one-cycle
  // pulse and a held level behave the same.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    checkDone   = 1'b0;
    cnt_inc     = cnt + 1'b1;
    done_a      = seen_a | productDoneA;
    done_b      = seen_b | productDoneB;
    both_done   = done_a & done_b;
    hit_timeout = (cnt_inc == TIMEOUT_C);
    cap_a_en    = 1'b0;
    cap_b_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        cap_a_en = productDoneA & ~seen_a;
        cap_b_en = productDoneB & ~seen_b;
        if (both_done || hit_timeout) state_next = REPORT;
      end
      REPORT: begin
        checkDone  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      seen_a          <= 1'b0;
      seen_b          <= 1'b0;
      cap_a           <= '0;
      cap_b           <= '0;
      latencyA        <= '0;
      latencyB        <= '0;
      timingLeak      <= 1'b0;
      timingLeakDone  <= 1'b0;
      productMismatch <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt             <= '0;
            seen_a          <= 1'b0;
            seen_b          <= 1'b0;
            cap_a           <= '0;
            cap_b           <= '0;
            latencyA        <= '0;
            latencyB        <= '0;
            timingLeak      <= 1'b0;
            timingLeakDone  <= 1'b0;
            productMismatch <= 1'b0;
            timeout         <= 1'b0;
          end
        end
        RUN: begin
          cnt <= (cnt == TIMEOUT_C) ? cnt : cnt_inc;
          if (cap_a_en) begin
            seen_a   <= 1'b1;
            latencyA <= cnt_inc;
            cap_a    <= productA;
          end
          if (cap_b_en) begin
            seen_b   <= 1'b1;
            latencyB <= cnt_inc;
            cap_b    <= productB;
          end
          if (done_a != done_b) timingLeak <= 1'b1;
          // Completion of both sides wins over a timeout that lands on the same edge.
          if (!both_done && hit_timeout) timeout <= 1'b1;
        end
        REPORT: begin
          productMismatch <= timeout ? 1'b0 : (cap_a != cap_b);
          timingLeakDone  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
